truth_table_sequencer: RTL and testbench

- Sequences an exhaustive truth-table sweep of one generated combinational circuit (N_IN inputs, N_OUT outputs).
- Drives every input vector 0..2^N_IN-1 onto the circuit, waits a programmable settle time, captures the outputs and streams each (index, vector) pair over a valid/ready port.
- Folds all captured vectors into a rotating-XOR signature, so dataset circuits can be labelled and compared in hardware.
- Sits between the dataset control logic and the circuit under evaluation.

---
 rtl/truth_table_sequencer_if.sv | 31 +++
 rtl/truth_table_sequencer.sv | 130 +++++++++++++
 tb/tb_truth_table_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sequencer_if
//  Description : Result stream (valid/ready, index, captured vector) between
//                the truth-table sequencer and its consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_sequencer_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [N_IN-1:0]   out_index;
    logic [N_OUT-1:0]  out_vector;

    modport master (
        output out_valid,
        input  out_ready,
        output out_index,
        output out_vector
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_index,
        input  out_vector
    );
endinterface
`default_nettype wire

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sequencer
//  Description : Exhaustive truth-table sweep of a combinational circuit with
//                settle delay, streamed results and rotating-XOR signature.
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 8,
    parameter int SETTLE = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              abort,
    output logic                   busy,
    output logic                   done,
    output logic [N_IN-1:0]        dut_x,
    input  wire logic [N_OUT-1:0]  dut_f,
    output logic [N_OUT-1:0]       signature,
    truth_table_sequencer_if.master out_if
);

    localparam logic [7:0]      c_settle_m1 = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] c_last_x    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [N_IN-1:0]   r_x, w_x_nxt;
    logic [N_OUT-1:0]  r_sig, w_sig_nxt;
    logic              r_valid, w_valid_nxt;
    logic [N_IN-1:0]   r_index, w_index_nxt;
    logic [N_OUT-1:0]  r_vector, w_vector_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_sig    <= '0;
            r_valid  <= 1'b0;
            r_index  <= '0;
            r_vector <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_x      <= w_x_nxt;
            r_sig    <= w_sig_nxt;
            r_valid  <= w_valid_nxt;
            r_index  <= w_index_nxt;
            r_vector <= w_vector_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_x_nxt      = r_x;
        w_sig_nxt    = r_sig;
        w_valid_nxt  = r_valid;
        w_index_nxt  = r_index;
        w_vector_nxt = r_vector;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_x_nxt     = '0;
                    w_sig_nxt   = '0;
                    w_cnt_nxt   = c_settle_m1;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else if (r_cnt == 8'd0) begin
                    w_vector_nxt = dut_f;
                    w_index_nxt  = r_x;
                    w_sig_nxt    = {r_sig[N_OUT-2:0], r_sig[N_OUT-1]} ^ dut_f;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_PRESENT;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_PRESENT: begin
                // abort takes precedence over a simultaneous accept
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else if (r_valid && out_if.out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_x == c_last_x) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_x_nxt     = r_x + 1'b1;
                        w_cnt_nxt   = c_settle_m1;
                        w_state_nxt = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign busy              = (r_state != S_IDLE);
    assign done              = (r_state == S_DONE);
    assign dut_x             = r_x;
    assign signature         = r_sig;
    assign out_if.out_valid  = r_valid;
    assign out_if.out_index  = r_index;
    assign out_if.out_vector = r_vector;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_sequencer
//  Description : Scoreboard bench for truth_table_sequencer (SETTLE=1 and 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sequencer;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, abort_a, start_b, abort_b;
    logic       busy_a, done_a, busy_b, done_b;
    logic [2:0] dut_x_a, dut_x_b;
    logic [7:0] dut_f_a, dut_f_b, sig_a, sig_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int acc_a[$];
    int acc_b[$];
    exp_t exp_a[$];
    exp_t exp_b[$];

    truth_table_sequencer_if #(.N_IN(3), .N_OUT(8)) if_a ();
    truth_table_sequencer_if #(.N_IN(3), .N_OUT(8)) if_b ();

    assign dut_f_a = {5'b0, dut_x_a};
    assign dut_f_b = ~{5'b0, dut_x_b};

    truth_table_sequencer #(.N_IN(3), .N_OUT(8), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .dut_x(dut_x_a), .dut_f(dut_f_a),
        .signature(sig_a), .out_if(if_a)
    );

    truth_table_sequencer #(.N_IN(3), .N_OUT(8), .SETTLE(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .dut_x(dut_x_b), .dut_f(dut_f_b),
        .signature(sig_b), .out_if(if_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitors: pop an expectation on every handshake.
    always @(negedge clk) begin
        if (if_a.out_valid && if_a.out_ready) begin
            exp_t e;
            n_vec++;
            if (exp_a.size() == 0) begin
                n_err++;
                $display("FAIL a_unexpected: got idx %0d vec 0x%0h, required no result", if_a.out_index, if_a.out_vector);
            end else begin
                e = exp_a.pop_front();
                if (if_a.out_index !== e.idx || if_a.out_vector !== e.vec) begin
                    n_err++;
                    $display("FAIL a_result: got idx %0d vec 0x%0h, required idx %0d vec 0x%0h", if_a.out_index, if_a.out_vector, e.idx, e.vec);
                end
            end
            acc_a.push_back(cyc);
        end
        if (done_a) done_cnt_a++;
    end

    always @(negedge clk) begin
        if (if_b.out_valid && if_b.out_ready) begin
            exp_t e;
            n_vec++;
            if (exp_b.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected: got idx %0d vec 0x%0h, required no result", if_b.out_index, if_b.out_vector);
            end else begin
                e = exp_b.pop_front();
                if (if_b.out_index !== e.idx || if_b.out_vector !== e.vec) begin
                    n_err++;
                    $display("FAIL b_result: got idx %0d vec 0x%0h, required idx %0d vec 0x%0h", if_b.out_index, if_b.out_vector, e.idx, e.vec);
                end
            end
            acc_b.push_back(cyc);
        end
        if (done_b) done_cnt_b++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.idx = 3'(i);
            e.vec = 8'(i);
            exp_a.push_back(e);
        end
    endtask

    task automatic push_b(input int lo, input int hi);
        exp_t e;
        logic [7:0] v;
        for (int i = lo; i <= hi; i++) begin
            v     = 8'(i);
            e.idx = 3'(i);
            e.vec = ~v;
            exp_b.push_back(e);
        end
    endtask

    task automatic pulse_start_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Returns at the negedge on which done is seen high.
    task automatic wait_done(input bit use_b, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (use_b ? done_b : done_a) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_done: got no done pulse, required one within 300 cycles", name);
        end
    endtask

    task automatic full_sweep_a(input string name);
        push_a(0, 7);
        pulse_start_a();
        wait_done(1'b0, name);
        check({name, "_sig"}, 32'(sig_a), 32'h0F);
        check({name, "_queue"}, 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int k;
        bit found;
        bit ok;

        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        if_a.out_ready = 1'b1;
        if_b.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_valid", 32'(if_a.out_valid), 32'd0);
        check("rst_x", 32'(dut_x_a), 32'd0);
        check("rst_sig", 32'(sig_a), 32'd0);
        check("rst_vec", 32'(if_a.out_vector), 32'd0);
        check("rst_idx", 32'(if_a.out_index), 32'd0);
        tick();

        // Free-running sweep
        acc_a.delete();
        d0 = done_cnt_a;
        push_a(0, 7);
        pulse_start_a();
        check("t1_busy_start", 32'(busy_a), 32'd1);
        wait_done(1'b0, "t1");
        check("t1_sig", 32'(sig_a), 32'h0F);
        check("t1_busy_at_done", 32'(busy_a), 32'd1);
        @(negedge clk);
        check("t1_busy_after", 32'(busy_a), 32'd0);
        check("t1_done_after", 32'(done_a), 32'd0);
        repeat (3) tick();
        check("t1_done_count", 32'(done_cnt_a - d0), 32'd1);
        check("t1_queue", 32'(exp_a.size()), 32'd0);
        check("t1_results", 32'(acc_a.size()), 32'd8);
        ok = 1'b1;
        for (int i = 1; i < acc_a.size(); i++)
            if (acc_a[i] - acc_a[i-1] != 2) ok = 1'b0;
        check("t1_spacing", 32'(ok), 32'd1);
        tick();

        // Backpressure hold at index 3
        push_a(0, 7);
        pulse_start_a();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (dut_x_a == 3'd3) begin
                if_a.out_ready = 1'b0;
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t2_reach3", 32'(found), 32'd1);
        for (int i = 0; i < 20 && !if_a.out_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t2_valid_%0d", i), 32'(if_a.out_valid), 32'd1);
            check($sformatf("t2_idx_%0d", i), 32'(if_a.out_index), 32'd3);
            check($sformatf("t2_vec_%0d", i), 32'(if_a.out_vector), 32'h03);
            check($sformatf("t2_x_%0d", i), 32'(dut_x_a), 32'd3);
            @(posedge clk);
            #1;
        end
        if_a.out_ready = 1'b1;
        wait_done(1'b0, "t2");
        check("t2_sig", 32'(sig_a), 32'h0F);
        check("t2_queue", 32'(exp_a.size()), 32'd0);
        tick();

        // Abort on the accept edge of index 2
        d0 = done_cnt_a;
        push_a(0, 2);
        pulse_start_a();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (if_a.out_valid && if_a.out_index == 3'd2) begin
                abort_a = 1'b1;
                tick();
                abort_a = 1'b0;
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t3_reach2", 32'(found), 32'd1);
        @(negedge clk);
        check("t3_busy", 32'(busy_a), 32'd0);
        check("t3_valid", 32'(if_a.out_valid), 32'd0);
        check("t3_sig", 32'(sig_a), 32'h00);
        check("t3_x", 32'(dut_x_a), 32'd2);
        repeat (4) tick();
        check("t3_no_done", 32'(done_cnt_a - d0), 32'd0);
        check("t3_queue", 32'(exp_a.size()), 32'd0);
        full_sweep_a("t3_resweep");
        tick();

        // start while busy is ignored
        d0 = done_cnt_a;
        push_a(0, 7);
        start_a = 1'b1;
        repeat (4) tick();
        start_a = 1'b0;
        wait_done(1'b0, "t4");
        check("t4_sig", 32'(sig_a), 32'h0F);
        repeat (4) tick();
        check("t4_done_count", 32'(done_cnt_a - d0), 32'd1);
        check("t4_queue", 32'(exp_a.size()), 32'd0);

        // Reset mid-sweep at index 5
        push_a(0, 5);
        pulse_start_a();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (if_a.out_valid && if_a.out_index == 3'd5) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t5_reach5", 32'(found), 32'd1);
        @(negedge clk);
        check("t5_busy", 32'(busy_a), 32'd0);
        check("t5_valid", 32'(if_a.out_valid), 32'd0);
        check("t5_x", 32'(dut_x_a), 32'd0);
        check("t5_sig", 32'(sig_a), 32'd0);
        check("t5_queue", 32'(exp_a.size()), 32'd0);
        tick();
        full_sweep_a("t5_resweep");
        tick();

        // Settle timing with SETTLE=4 and an inverting circuit
        acc_b.delete();
        push_b(0, 7);
        start_b = 1'b1;
        tick();
        k = cyc;
        start_b = 1'b0;
        wait_done(1'b1, "t6");
        check("t6_sig", 32'(sig_b), 32'h0F);
        check("t6_queue", 32'(exp_b.size()), 32'd0);
        check("t6_results", 32'(acc_b.size()), 32'd8);
        if (acc_b.size() > 0)
            check("t6_first_latency", 32'(acc_b[0] - k), 32'd4);
        ok = 1'b1;
        for (int i = 1; i < acc_b.size(); i++)
            if (acc_b[i] - acc_b[i-1] != 5) ok = 1'b0;
        check("t6_spacing", 32'(ok), 32'd1);
        @(negedge clk);
        check("t6_busy_after", 32'(busy_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
